instr_mem_sync: RTL and testbench

- Parametrised, clocked successor to the combinational byte-array instruction memory.
- Byte-addressed, big-endian word store with a registered one-cycle fetch port toward IF, plus a word-wide program-load port for the bench/boot loader.
- Adds a sequential clear engine, pipeline hold, and misaligned / out-of-range fetch detection; illegal fetches return a NOOP (0x00000000).

---
 rtl/instr_mem_sync_if.sv | 37 +++
 rtl/instr_mem_sync.sv | 137 +++++++++++++
 tb/tb_instr_mem_sync.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/instr_mem_sync_if.sv
// Fetch / load / clear bus for instr_mem_sync.
// Optional IMEM_PARITY_EN adds the parity_err response signal.
interface instr_mem_sync_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              inst_hold;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              inst_err;
`ifdef IMEM_PARITY_EN
  logic              parity_err;
`endif
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              clr_start;
  logic              clr_busy;

  modport master (
    output fetch_req, fetch_addr, inst_hold, load_en, load_addr, load_data, clr_start,
`ifdef IMEM_PARITY_EN
    input  parity_err,
`endif
    input  fetch_ready, inst, inst_valid, inst_err, clr_busy
  );

  modport slave (
    input  fetch_req, fetch_addr, inst_hold, load_en, load_addr, load_data, clr_start,
`ifdef IMEM_PARITY_EN
    output parity_err,
`endif
    output fetch_ready, inst, inst_valid, inst_err, clr_busy
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous big-endian instruction memory: one-cycle registered fetch,
// word load port, sequential clear engine, misaligned/out-of-range detection.
// Optional feature macro: IMEM_PARITY_EN (per-byte even parity + parity_err).
module instr_mem_sync #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = 6
) (
  input logic              clk,
  input logic              rst_n,
  instr_mem_sync_if.slave  bus
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  // Storage; byte at addr+0 lives in [31:24]. Not reset.
  logic [31:0]       mem [WORDS];
`ifdef IMEM_PARITY_EN
  logic [3:0]        par [WORDS];
  logic [3:0]        wr_par;
  logic [3:0]        rd_par_bad;
`endif

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic              load_in_range;
  logic              fetch_ok;
  logic              accept;
  logic [IDX_W-1:0]  rd_idx;

  assign load_in_range   = bus.load_addr < ADDR_W'(DEPTH_BYTES);
  assign fetch_ok        = (bus.fetch_addr[1:0] == 2'b00) &&
                           (bus.fetch_addr < ADDR_W'(DEPTH_BYTES));
  assign bus.fetch_ready = (state_q == IDLE) & ~bus.load_en & ~bus.inst_hold;
  assign accept          = bus.fetch_req & bus.fetch_ready;
  assign bus.clr_busy    = (state_q == CLEAR);
  assign rd_idx          = bus.fetch_addr[IDX_W+1:2];

  // State and clear-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, clear counter and the single memory write port
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = bus.load_addr[IDX_W+1:2];
    wr_data = bus.load_data;
    case (state_q)
      IDLE: begin
        // Out-of-range loads are dropped rather than aliased.
        wr_en = bus.load_en & load_in_range;
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // clr_start and load_en are ignored while clearing.
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IMEM_PARITY_EN
  // Even parity per byte; clear writes zero data so zero parity matches.
  always_comb begin
    wr_par = '0;
    if (state_q == IDLE)
      for (int i = 0; i < 4; i++) wr_par[i] = ^bus.load_data[8*i +: 8];
  end

  // Recompute parity of the read word and compare with stored bits
  always_comb begin
    rd_par_bad = '0;
    for (int i = 0; i < 4; i++)
      rd_par_bad[i] = (^mem[rd_idx][8*i +: 8]) ^ par[rd_idx][i];
  end
`endif

  // Memory write; reads in the same edge see the old contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
      par[wr_idx] <= wr_par;
`endif
    end
  end

  // Fetch response registers, frozen under inst_hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.inst       <= '0;
      bus.inst_valid <= 1'b0;
      bus.inst_err   <= 1'b0;
`ifdef IMEM_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else if (!bus.inst_hold) begin
      if (accept) begin
        bus.inst_valid <= 1'b1;
        bus.inst_err   <= ~fetch_ok;
        bus.inst       <= fetch_ok ? mem[rd_idx] : 32'h0000_0000;
`ifdef IMEM_PARITY_EN
        bus.parity_err <= fetch_ok & (|rd_par_bad);
`endif
      end else begin
        // inst keeps its last value; only the qualifiers drop.
        bus.inst_valid <= 1'b0;
        bus.inst_err   <= 1'b0;
`ifdef IMEM_PARITY_EN
        bus.parity_err <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed test of instr_mem_sync with hand-computed expectations.
module tb_instr_mem_sync;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;
  int   busy_cnt;

  instr_mem_sync_if #(.ADDR_W(32)) bus ();

  instr_mem_sync #(.DEPTH_BYTES(256), .ADDR_W(32), .IDX_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    tick();
    bus.fetch_req  = 1'b0;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.fetch_req = 0; bus.fetch_addr = 0; bus.inst_hold = 0;
    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.clr_start = 0;
    tick(); tick();
    chk("rst_inst",  bus.inst, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_err",   32'(bus.inst_err), 0);
    chk("rst_busy",  32'(bus.clr_busy), 0);
    rst_n = 1'b1;
    tick();

    load(32'h0, 32'h2003_0008);
    load(32'h4, 32'h2004_0001);
    load(32'h8, 32'h2005_FFFF);
    load(32'hFC, 32'h0000_000C);
    load(32'h100, 32'hBAD0_BAD0);   // out of range, must be dropped

    // Back-to-back fetches
    bus.fetch_req = 1; bus.fetch_addr = 32'h0; #1;
    chk("ready_idle", 32'(bus.fetch_ready), 1);
    tick();
    chk("f0_inst", bus.inst, 32'h2003_0008);
    chk("f0_valid", 32'(bus.inst_valid), 1);
    chk("f0_err", 32'(bus.inst_err), 0);
    bus.fetch_addr = 32'h4; tick();
    chk("f4_inst", bus.inst, 32'h2004_0001);
    chk("f4_valid", 32'(bus.inst_valid), 1);
    bus.fetch_addr = 32'h8; tick();
    chk("f8_inst", bus.inst, 32'h2005_FFFF);
    chk("f8_err", 32'(bus.inst_err), 0);
    bus.fetch_req = 0; tick();
    chk("idle_valid", 32'(bus.inst_valid), 0);
    chk("idle_keep", bus.inst, 32'h2005_FFFF);

    // Illegal fetches
    fetch(32'h2);
    chk("mis_inst", bus.inst, 32'h0);
    chk("mis_err", 32'(bus.inst_err), 1);
    chk("mis_valid", 32'(bus.inst_valid), 1);
    fetch(32'h4);
    chk("legal_err", 32'(bus.inst_err), 0);
    fetch(32'h100);
    chk("oor_inst", bus.inst, 32'h0);
    chk("oor_err", 32'(bus.inst_err), 1);
    chk("oor_valid", 32'(bus.inst_valid), 1);
    fetch(32'hFC);
    chk("top_word", bus.inst, 32'h0000_000C);
    chk("top_err", 32'(bus.inst_err), 0);

    // Hold
    fetch(32'h0);
    chk("h_pre", bus.inst, 32'h2003_0008);
    bus.inst_hold = 1; bus.fetch_req = 1; bus.fetch_addr = 32'h4; #1;
    chk("h_ready", 32'(bus.fetch_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_inst", bus.inst, 32'h2003_0008);
      chk("h_valid", 32'(bus.inst_valid), 1);
    end
    bus.inst_hold = 0; #1;
    chk("h_rel_ready", 32'(bus.fetch_ready), 1);
    tick();
    bus.fetch_req = 0;
    chk("h_rel_inst", bus.inst, 32'h2004_0001);

    // Load wins over fetch
    bus.load_en = 1; bus.load_addr = 32'h10; bus.load_data = 32'h0085_2020;
    bus.fetch_req = 1; bus.fetch_addr = 32'h10; #1;
    chk("lw_ready", 32'(bus.fetch_ready), 0);
    tick();
    chk("lw_novalid", 32'(bus.inst_valid), 0);
    bus.load_en = 0;
    tick();
    bus.fetch_req = 0;
    chk("lw_inst", bus.inst, 32'h0085_2020);

    // Full clear, with a redundant clr_start mid-way that must be ignored
    load(32'h24, 32'hDEAD_BEEF);
    fetch(32'h24);
    chk("pre_clr", bus.inst, 32'hDEAD_BEEF);
    bus.clr_start = 1; tick(); bus.clr_start = 0;
    busy_cnt = 0;
    bus.fetch_req = 1; bus.fetch_addr = 32'h0;
    for (int i = 0; i < 200 && bus.clr_busy; i++) begin
      busy_cnt++;
      if (busy_cnt == 1) chk("clr_ready", 32'(bus.fetch_ready), 0);
      if (busy_cnt == 30) bus.clr_start = 1;
      tick();
      bus.clr_start = 0;
    end
    bus.fetch_req = 0;
    chk("clr_cycles", 32'(busy_cnt), 64);
    fetch(32'h24);
    chk("clr_w9", bus.inst, 32'h0);
    fetch(32'hFC);
    chk("clr_w63", bus.inst, 32'h0);

    // Reset aborts clear part-way
    load(32'h0, 32'h1111_1111);
    load(32'hFC, 32'h0000_000C);
    bus.clr_start = 1; tick(); bus.clr_start = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("ab_busy_pre", 32'(bus.clr_busy), 1);
    rst_n = 0; #1;
    chk("ab_busy", 32'(bus.clr_busy), 0);
    chk("ab_valid", 32'(bus.inst_valid), 0);
    tick();
    rst_n = 1;
    tick();
    fetch(32'h0);
    chk("ab_w0", bus.inst, 32'h0);
    fetch(32'hFC);
    chk("ab_w63", bus.inst, 32'h0000_000C);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
